// File: rtl/byte_stream_mem_writer.sv
// byte_stream_mem_writer
// Avalon-MM write initiator that packs a byte stream little-endian into
// 32-bit words and writes them to on-chip RAM, one word per transfer.
// Each command gives a base word address and a byte length. The last
// partial word is written with only its filled lanes enabled.
//
// Handshake semantics (cmd_* and in_*): a beat transfers on a rising edge
// where valid and ready are both high. Once valid is raised, the source
// holds it and the payload steady until that edge. ready is registered
// here, so it never depends on valid in the same cycle.
//
// Bus side: chipselect and write rise together for one transfer. The
// transfer ends on the first edge where waitrequest is low. Until then,
// address, byteenable and writedata stay steady.

module byte_stream_mem_writer #(
  parameter int ADDR_W    = 15,
  parameter int LEN_W     = 16,
  parameter int MEM_WORDS = 17740
) (
  input  logic              clk,
  input  logic              reset,

  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,

  // byte stream channel
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,

  // Avalon-MM write master
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic              waitrequest,

  // status
  output logic              busy,
  output logic              done,

  // current FSM state, exposed for checkers (0 IDLE, 1 FILL, 2 WRITE, 3 DONE)
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last valid word address. The RAM is not a power of two deep, so the
  // wrap point has to be compared explicitly.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  state_t            state;
  logic [1:0]        lane_cnt;   // next byte lane to fill in the current word
  logic [LEN_W-1:0]  remaining;  // bytes of the command not yet accepted

  // Fired-handshake terms. They are used only inside the state they belong to.
  logic cmd_fire;
  logic in_fire;
  logic word_full;
  logic last_byte;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;
  assign word_full = (lane_cnt == 2'd3);
  assign last_byte = (remaining == LEN_W'(1));

  assign fsm_state = state;

  // Main controller. It holds the state, the counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      in_ready   <= 1'b0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      address    <= '0;
      byteenable <= 4'b0000;
      writedata  <= 32'h0000_0000;
      lane_cnt   <= 2'd0;
      remaining  <= '0;
    end else begin
      case (state)
        // Wait for a command. A zero-length command skips the bus entirely
        // and goes straight to the completion pulse.
        S_IDLE: begin
          if (cmd_fire) begin
            address    <= cmd_base;
            remaining  <= cmd_len;
            lane_cnt   <= 2'd0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0000_0000;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (cmd_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end

        // Collect bytes into lanes, lowest lane first. A word is sent either
        // when lane 3 is filled or when the command runs out of bytes.
        S_FILL: begin
          if (in_fire) begin
            writedata[{lane_cnt, 3'b000} +: 8] <= in_data;
            byteenable[lane_cnt]               <= 1'b1;
            remaining                          <= remaining - LEN_W'(1);
            lane_cnt                           <= lane_cnt + 2'd1;
            if (word_full || last_byte) begin
              state      <= S_WRITE;
              in_ready   <= 1'b0;
              chipselect <= 1'b1;
              write      <= 1'b1;
            end
          end
        end

        // Present one write until the slave drops waitrequest. Then move
        // to the next word and clear the packing registers.
        S_WRITE: begin
          if (!waitrequest) begin
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0000_0000;
            lane_cnt   <= 2'd0;
            address    <= (address == LAST_ADDR) ? '0 : address + ADDR_W'(1);
            if (remaining == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end

        // One-cycle completion pulse. busy is still high in this cycle.
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          cmd_ready  <= 1'b1;
          in_ready   <= 1'b0;
          chipselect <= 1'b0;
          write      <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
